// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_UPDATE_PC = 3'd5,
    ST_HALTED    = 3'd6
  } state_e;

  // Low-nibble opcode values; anything above bit 3 makes the opcode illegal.
  localparam logic [3:0] OP_ALU     = 4'h0;
  localparam logic [3:0] OP_ALU_IMM = 4'h1;
  localparam logic [3:0] OP_LOAD    = 4'h2;
  localparam logic [3:0] OP_STORE   = 4'h3;
  localparam logic [3:0] OP_BR      = 4'h4;
  localparam logic [3:0] OP_BMI     = 4'h5;
  localparam logic [3:0] OP_BPL     = 4'h6;
  localparam logic [3:0] OP_BZ      = 4'h7;
  localparam logic [3:0] OP_MOVE    = 4'h8;
  localparam logic [3:0] OP_CMOV    = 4'h9;
  localparam logic [3:0] OP_NOP     = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [1:0] DSEL_ALU  = 2'b00;
  localparam logic [1:0] DSEL_MEM  = 2'b01;
  localparam logic [1:0] DSEL_CMOV = 2'b10;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BR   = 3'b001;
  localparam logic [2:0] BR_BMI  = 3'b010;
  localparam logic [2:0] BR_BPL  = 3'b011;
  localparam logic [2:0] BR_BZ   = 3'b100;

  // Where EXECUTE goes next.
  typedef enum logic [1:0] {
    CLS_WB   = 2'd0,
    CLS_MEM  = 2'd1,
    CLS_PC   = 2'd2,
    CLS_HALT = 2'd3
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic       mem_wr;
    logic       imm_sel;
    logic [1:0] data_sel;
    logic [2:0] branch;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-word decode; illegal opcodes decode as NOP.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op_i,
  output ctrl_word_t      cw_o
);

  logic [3:0] low;
  logic       illegal;

  assign low     = op_i[3:0];
  assign illegal = |(op_i >> 4);

  // Table lookup on the low nibble; undefined codes fall through as NOP.
  always_comb begin
    cw_o         = '0;
    cw_o.cls     = CLS_PC;
    cw_o.illegal = illegal;
    if (!illegal) begin
      case (low)
        OP_ALU, OP_MOVE: cw_o.cls = CLS_WB;
        OP_ALU_IMM: begin
          cw_o.cls     = CLS_WB;
          cw_o.imm_sel = 1'b1;
        end
        OP_CMOV: begin
          cw_o.cls      = CLS_WB;
          cw_o.data_sel = DSEL_CMOV;
        end
        OP_LOAD: begin
          cw_o.cls      = CLS_MEM;
          cw_o.imm_sel  = 1'b1;
          cw_o.data_sel = DSEL_MEM;
        end
        OP_STORE: begin
          cw_o.cls     = CLS_MEM;
          cw_o.imm_sel = 1'b1;
          cw_o.mem_wr  = 1'b1;
        end
        OP_BR: begin
          cw_o.imm_sel = 1'b1;
          cw_o.branch  = BR_BR;
        end
        OP_BMI: begin
          cw_o.imm_sel = 1'b1;
          cw_o.branch  = BR_BMI;
        end
        OP_BPL: begin
          cw_o.imm_sel = 1'b1;
          cw_o.branch  = BR_BPL;
        end
        OP_BZ: begin
          cw_o.imm_sel = 1'b1;
          cw_o.branch  = BR_BZ;
        end
        OP_HALT: cw_o.cls = CLS_HALT;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit_param.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/mem/writeback/update-PC/halt.
// Latency: 4 (branch/NOP), 5 (ALU/STORE), 6 (LOAD) cycles per instruction with no waits.
// Backpressure: stalls in FETCH on fetch_ready and in MEM on mem_ready (bounded by MEM_TIMEOUT).
module control_unit_param
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             continue_i,
  input  logic [OP_W-1:0]  op_code,
  input  logic             fetch_ready,
  input  logic             mem_ready,
  output logic             IRload,
  output logic             loadPC,
  output logic             writeReg,
  output logic             MemEn,
  output logic             MemWen,
  output logic             IMMsel,
  output logic [1:0]       DataSel,
  output logic [2:0]       BRANCH,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             cont_q;
  logic             rst_q;
  logic             cont_rise;
  logic             hold;
  ctrl_word_t       cw;

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .op_i (op_q),
    .cw_o (cw)
  );

  // Only a fresh 0->1 on continue resumes; a level already high is ignored.
  assign cont_rise = continue_i & ~cont_q;
  // Outputs stay quiet while reset is high and for the cycle right after it.
  assign hold      = reset | rst_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cont_q  <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cont_q  <= continue_i;
      rst_q   <= 1'b0;
    end
  end

  // Next-state logic, opcode latch, MEM timeout counter, sticky error.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    err_d   = err_q;
    case (state_q)
      ST_FETCH: begin
        // IRload is masked in the post-reset cycle, so no fetch is accepted then.
        if (fetch_ready && !rst_q) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d    = op_code;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (cw.illegal) err_d = 1'b1;
        case (cw.cls)
          CLS_WB:   state_d = ST_WRITEBACK;
          CLS_MEM:  state_d = ST_MEM;
          CLS_HALT: state_d = ST_HALTED;
          default:  state_d = ST_UPDATE_PC;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = cw.mem_wr ? ST_UPDATE_PC : ST_WRITEBACK;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_WRITEBACK: state_d = ST_UPDATE_PC;
      ST_UPDATE_PC: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_FETCH;
      end
      ST_HALTED: begin
        if (cont_rise) begin
          err_d   = 1'b0;
          state_d = ST_UPDATE_PC;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Moore outputs from state and latched opcode, silenced around reset.
  always_comb begin
    IRload   = 1'b0;
    loadPC   = 1'b0;
    writeReg = 1'b0;
    MemEn    = 1'b0;
    MemWen   = 1'b0;
    IMMsel   = 1'b0;
    DataSel  = DSEL_ALU;
    BRANCH   = BR_NONE;
    halted   = 1'b0;
    if (!hold) begin
      case (state_q)
        ST_FETCH:     IRload   = 1'b1;
        ST_MEM: begin
          MemEn  = 1'b1;
          MemWen = cw.mem_wr;
        end
        ST_WRITEBACK: writeReg = 1'b1;
        ST_UPDATE_PC: loadPC   = 1'b1;
        ST_HALTED:    halted   = 1'b1;
        default: ;
      endcase
      if (state_q inside {ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_UPDATE_PC}) begin
        IMMsel  = cw.imm_sel;
        DataSel = cw.data_sel;
        BRANCH  = cw.branch;
      end
    end
  end

  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit_param.sv
// Randomised scoreboard bench for control_unit_param (OP_W=6, CNT_W=4, MEM_TIMEOUT=15).
// Driver issues instructions with random waits; monitor checks each retired instruction.
// A summary line reports comparisons made and failures.
module tb_control_unit_param;

  localparam int OP_W    = 6;
  localparam int CNT_W   = 4;
  localparam int TMO     = 15;
  localparam int N_INSTR = 60;

  logic             clk = 1'b0;
  logic             reset;
  logic             continue_i;
  logic [OP_W-1:0]  op_code;
  logic             fetch_ready;
  logic             mem_ready;
  logic             IRload, loadPC, writeReg, MemEn, MemWen, IMMsel;
  logic [1:0]       DataSel;
  logic [2:0]       BRANCH;
  logic             halted, err;
  logic [CNT_W-1:0] instr_count;

  always #5 clk = ~clk;

  control_unit_param #(.OP_W(OP_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .continue_i  (continue_i),
    .op_code     (op_code),
    .fetch_ready (fetch_ready),
    .mem_ready   (mem_ready),
    .IRload      (IRload),
    .loadPC      (loadPC),
    .writeReg    (writeReg),
    .MemEn       (MemEn),
    .MemWen      (MemWen),
    .IMMsel      (IMMsel),
    .DataSel     (DataSel),
    .BRANCH      (BRANCH),
    .halted      (halted),
    .err         (err),
    .instr_count (instr_count)
  );

  // Expected summary of one instruction, from first FETCH cycle to its loadPC cycle.
  typedef struct {
    int cyc, irl, men, mwen, wr, hlt, errh, ds_wr;
    int imm, ds, br, err, cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;

  int a_cyc, a_irl, a_men, a_mwen, a_wr, a_hlt, a_errh, a_dswr, a_selbad;
  bit armed = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int outs();
    return int'({IRload, loadPC, writeReg, MemEn, MemWen, IMMsel, DataSel, BRANCH, halted});
  endfunction

  task automatic clear_acc();
    a_cyc = 0; a_irl = 0; a_men = 0; a_mwen = 0; a_wr = 0;
    a_hlt = 0; a_errh = 0; a_dswr = 0; a_selbad = 0;
  endtask

  // Monitor: accumulate observed behaviour, compare on every loadPC pulse.
  initial begin : monitor
    exp_t e;
    clear_acc();
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (IRload) armed = 1'b1;
        if (armed) begin
          a_cyc++;
          a_irl  += int'(IRload);
          a_men  += int'(MemEn);
          a_mwen += int'(MemWen);
          a_wr   += int'(writeReg);
          a_hlt  += int'(halted);
          a_errh += int'(halted & err);
          if (writeReg) a_dswr = int'(DataSel);
          if ((IRload || halted) && ({IMMsel, DataSel, BRANCH} != 6'd0)) a_selbad++;
          if (loadPC) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_loadpc", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("cycles", a_cyc, e.cyc);
              chk("irload_cycles", a_irl, e.irl);
              chk("memen_cycles", a_men, e.men);
              chk("memwen_cycles", a_mwen, e.mwen);
              chk("writereg_pulses", a_wr, e.wr);
              chk("halted_cycles", a_hlt, e.hlt);
              chk("err_while_halted", a_errh, e.errh);
              chk("datasel_at_wr", a_dswr, e.ds_wr);
              chk("sel_outside_window", a_selbad, 0);
              chk("immsel", int'(IMMsel), e.imm);
              chk("datasel", int'(DataSel), e.ds);
              chk("branch", int'(BRANCH), e.br);
              chk("err_at_loadpc", int'(err), e.err);
              chk("count_at_loadpc", int'(instr_count), e.cnt);
            end
            done_cnt++;
            clear_acc();
          end
        end
      end
    end
  end

  // Driver plus behavioural reference model.
  initial begin : driver
    int cyc, fw, mw, hold, hcnt, issued, r, k, m_cnt;
    bit planned, keep_op, first, legal, m_err;
    logic [OP_W-1:0] cur_op;
    logic [3:0] lo;
    exp_t e;

    cyc = 0; fw = 0; mw = 0; hold = 0; hcnt = 0; issued = 0; m_cnt = 0;
    planned = 1'b0; keep_op = 1'b0; first = 1'b1; m_err = 1'b0;
    cur_op = '0;

    // Reset with every input active: nothing may leak out.
    reset = 1'b1; continue_i = 1'b1; fetch_ready = 1'b1; mem_ready = 1'b1; op_code = '1;
    repeat (3) begin
      @(negedge clk);
      chk("outs_in_reset", outs(), 0);
    end
    chk("count_in_reset", int'(instr_count), 0);
    chk("err_in_reset", int'(err), 0);
    @(negedge clk);
    reset = 1'b0; fetch_ready = 1'b0; mon_en = 1'b1;
    #1 chk("outs_after_reset", outs(), 0);

    while ((issued < N_INSTR || done_cnt < N_INSTR) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (first) begin
        chk("irload_first_fetch", int'(IRload), 1);
        first = 1'b0;
      end
      op_code     = OP_W'($urandom);
      if (keep_op) begin
        op_code = cur_op;
        keep_op = 1'b0;
      end
      fetch_ready = 1'($urandom);
      mem_ready   = 1'($urandom);

      if (IRload) begin
        fetch_ready = 1'b0;
        if (issued < N_INSTR) begin
          if (!planned) begin
            planned = 1'b1;
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 4);
            hold = $urandom_range(0, 3);
            hcnt = 0;
            r = $urandom_range(0, 99);
            if (r < 8)       cur_op = {2'($urandom_range(1, 3)), 4'($urandom)};
            else if (r < 14) cur_op = 6'h0F;
            else             cur_op = {2'b00, 4'($urandom_range(0, 14))};
            lo    = cur_op[3:0];
            legal = (cur_op[5:4] == 2'b00);
            if (legal && (lo == 4'h2 || lo == 4'h3) && $urandom_range(0, 5) == 0) mw = 1000;

            // Reference model: FETCH waits + DECODE + EXECUTE + UPDATE_PC, plus class extras.
            e.irl = fw + 1; e.men = 0; e.mwen = 0; e.wr = 0; e.hlt = 0; e.errh = 0;
            e.imm = 0; e.ds = 0; e.br = 0; e.ds_wr = 0;
            e.cyc = fw + 4;
            k = legal ? int'(lo) : 14;
            if (!legal) m_err = 1'b1;
            if (k == 0 || k == 1 || k == 8 || k == 9) begin
              e.wr = 1; e.cyc++;
              e.imm = (k == 1) ? 1 : 0;
              e.ds = (k == 9) ? 2 : 0;
              e.ds_wr = e.ds;
            end else if (k == 2 || k == 3) begin
              e.imm = 1;
              e.ds = (k == 2) ? 1 : 0;
              if (mw >= TMO) begin
                e.men = TMO;
                e.mwen = (k == 3) ? TMO : 0;
                e.hlt = hold + 2;
                e.errh = e.hlt;
                e.cyc += TMO + hold + 2;
                m_err = 1'b0;
              end else begin
                e.men = mw + 1;
                e.mwen = (k == 3) ? mw + 1 : 0;
                e.cyc += mw + 1;
                if (k == 2) begin
                  e.wr = 1; e.cyc++; e.ds_wr = 1;
                end
              end
            end else if (k >= 4 && k <= 7) begin
              e.imm = 1;
              e.br = k - 3;
            end else if (k == 15) begin
              e.hlt = hold + 2;
              e.errh = m_err ? e.hlt : 0;
              e.cyc += hold + 2;
              m_err = 1'b0;
            end
            e.err = int'(m_err);
            e.cnt = m_cnt;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
          end
          if (fw > 0) begin
            fw--;
          end else begin
            fetch_ready = 1'b1;
            op_code = cur_op;
            keep_op = 1'b1;
            planned = 1'b0;
            issued++;
            exp_q.push_back(e);
          end
        end
      end

      if (MemEn) begin
        mem_ready = (mw == 0);
        if (mw > 0) mw--;
      end

      // In HALTED: keep the entry level for a while, then a clean 0 -> 1.
      if (halted) begin
        if (hcnt == hold)     continue_i = 1'b0;
        else if (hcnt > hold) continue_i = 1'b1;
        hcnt++;
      end else begin
        continue_i = 1'($urandom);
      end
    end

    fetch_ready = 1'b0;
    mem_ready = 1'b0;
    mon_en = 1'b0;
    chk("all_retired", done_cnt, N_INSTR);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("final_count", int'(instr_count), m_cnt);

    // Reset in the middle of a LOAD's MEM phase.
    @(negedge clk);                       // FETCH: hand over LOAD
    fetch_ready = 1'b1; op_code = 6'h02;
    @(negedge clk);                       // DECODE
    fetch_ready = 1'b0;
    @(negedge clk);                       // EXECUTE
    op_code = '1;
    @(negedge clk);                       // MEM, first cycle
    chk("load_memen", int'(MemEn), 1);
    chk("load_datasel", int'(DataSel), 1);
    chk("load_immsel", int'(IMMsel), 1);
    @(negedge clk);                       // MEM, second cycle: pull reset
    reset = 1'b1; mem_ready = 1'b1;
    #1 chk("outs_reset_in_mem", outs(), 0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1 chk("outs_after_mem_reset", outs(), 0);
    chk("count_after_mem_reset", int'(instr_count), 0);
    chk("err_after_mem_reset", int'(err), 0);
    @(negedge clk);
    chk("irload_after_mem_reset", int'(IRload), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
